hazard_controller: RTL
======================

# hazard_controller

Pipeline hazard and forwarding controller for the 5-stage pipelined CPU. It sits beside the ID stage and keeps its own shadow copy of the destination and control bits of the instructions in EX and MEM. From that copy and the decoded ID-stage instruction it produces:

- the PC / IF-ID write enable;
- the ID/EX bubble control;
- the `qa`/`qb` forwarding mux selects.

It also keeps a saturating count of stall cycles for performance debug.

## Interface

Parameters:
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `hold` in 1: global freeze, e.g. a memory wait. The pipeline and all controller state hold.
- `d_valid` in 1: the ID stage holds a real instruction.
- `d_rs` in 5: rs field of the ID instruction.
- `d_rt` in 5: rt field of the ID instruction.
- `d_use_rs` in 1: the ID instruction reads rs.
- `d_use_rt` in 1: the ID instruction reads rt. This includes store data.
- `d_wreg` in 1: control bit for the ID instruction.
- `d_m2reg` in 1: control bit for the ID instruction.
- `d_dest` in 5: destination register of the ID instruction.
- `wpcir` out 1: write enable for the PC and IF/ID. 1 = advance.
- `bubble` out 1: 1 = zero the wreg/m2reg/wmem bits written into ID/EX this edge.
- `fwda` out 2: qa source select.
- `fwdb` out 2: qb source select.
- `stall_cnt` out CNT_W: saturating count of load-use stall cycles.

## Operation

Shadow state:
- EX entry: `e_wreg`, `e_m2reg`, `e_dest`.
- MEM entry: `m_wreg`, `m_m2reg`, `m_dest`.

Forward select encoding, same for `fwda` and `fwdb`:
- 0: register file.
- 1: EX ALU result.
- 2: MEM ALU result.
- 3: MEM load data.

A source `s` (rs or rt) is matched only when its use bit is 1 and `s != 0`.

`fwdX` selection, in priority order:
1. `e_wreg && !e_m2reg && e_dest == s` → 1.
2. `m_wreg && m_dest == s` → 3 if `m_m2reg`, else 2.
3. Otherwise → 0.

EX always beats MEM.

Load-use stall:
- `stall = d_valid && !hold && e_wreg && e_m2reg && e_dest != 0 && ((d_use_rs && e_dest == d_rs) || (d_use_rt && e_dest == d_rt))`.
- `wpcir = !stall && !hold`.
- `bubble = stall || !d_valid`.
- During a stall cycle, `fwda`/`fwdb` are don't-care. The held instruction re-resolves next cycle from MEM (select 3).

Shadow update on each edge:
- `rst` → both entries cleared: wreg = 0, m2reg = 0, dest = 0.
- Else `hold` → both entries keep their values.
- Else:
  - MEM ← EX.
  - EX ← ID fields, with wreg and m2reg forced to 0 when `bubble`.

`stall_cnt`:
- `rst` → 0.
- Otherwise increments by 1 on each edge where `stall = 1`.
- Saturates at all-ones; no wrap.

No forwarding from WB. The register file writes on the falling edge, so a WB write is visible to an ID read in the same cycle.

## Timing

- `fwda`, `fwdb`, `stall`, `wpcir`, `bubble` are combinational from the shadow state and ID inputs. No added latency.
- Shadow registers track the datapath's ID/EX and EX/MEM registers exactly, edge for edge.
- Load-use costs exactly 1 stall cycle. It never costs 2, even for back-to-back dependent instructions.
- Reset values:
  - Shadows cleared, so `stall = 0` for any inputs.
  - `wpcir = !hold`.
  - `bubble = !d_valid`.
  - `fwda = fwdb = 0`.
  - `stall_cnt = 0`.
- `rst` asserted mid-stall: the next cycle has no stall; the pending load is discarded.
- `hold` together with a load-use condition: `stall` is forced to 0 and `stall_cnt` is unchanged. The hazard is re-evaluated once `hold` drops.
- `rs == rt`, both matching: both selects return the same value.

## Structure

- Shared package `cpu_pkg` holds:
  - the `FWD_RF`, `FWD_EALU`, `FWD_MALU`, `FWD_MDO` encodings;
  - the register-index width, 5.
- One sub-module: `fwd_sel`, a combinational per-source select. It is instantiated twice, once for rs and once for rt.
- Shadow registers, stall logic and the counter live in the top module.

## Test plan

- **ALU-ALU dependency:** `add $3,$1,$2` then `sub $4,$3,$5`. Expect `fwda = 1` in the sub's ID cycle and `wpcir = 1`.
- **Distance-2 dependency:** the same pair with one independent instruction between them. Expect `fwda = 2`.
- **Load-use on rt:** `lw $3,0($1)` then `add $4,$2,$3`.
  - Cycle 1: `stall = 1`, `wpcir = 0`, `bubble = 1`, `stall_cnt` 0→1.
  - Cycle 2: `fwdb = 3`, `wpcir = 1`.
- **Register 0:** a writer and a reader of `$0`. Expect `fwda = fwdb = 0` and no stall, including after `lw $0`.
- **Freeze:** assert `hold` for 3 cycles while a load-use is pending. Expect:
  - `wpcir = 0`, `stall = 0`, `stall_cnt` unchanged, shadows frozen;
  - after release, exactly 1 stall cycle.
- **Reset and saturation:**
  - Pulse `rst` mid-stall. Expect `stall = 0` and `stall_cnt = 0` the next cycle.
  - With `CNT_W = 4`, run 20 stalls. Expect `stall_cnt = 15`.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-index width and forwarding-select encodings
package cpu_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EALU = 2'd1,
    FWD_MALU = 2'd2,
    FWD_MDO  = 2'd3
  } fwd_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: forwarding source select for one ID-stage register operand
// use/s: operand read enable and index; e_*/m_*: EX and MEM shadow entries; sel: mux select
module fwd_sel
  import cpu_pkg::*;
(
  input  logic             use_s,
  input  logic [REG_W-1:0] s,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [REG_W-1:0] e_dest,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  input  logic [REG_W-1:0] m_dest,
  output logic [1:0]       sel
);
  logic hit;
  always_comb begin
    hit = use_s && (s != '0);
    sel = (hit && e_wreg && !e_m2reg && e_dest == s) ? FWD_EALU :
          (hit && m_wreg && m_dest == s) ? (m_m2reg ? FWD_MDO : FWD_MALU) : FWD_RF;
  end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, bubble and forwarding control beside the ID stage
// hold: global freeze; d_*: decoded ID instruction; wpcir: PC/IF-ID enable;
// bubble: zero ID/EX control bits; fwda/fwdb: qa/qb selects; stall_cnt: saturating stall count
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_wreg,
  input  logic             d_m2reg,
  input  logic [REG_W-1:0] d_dest,
  output logic             wpcir,
  output logic             bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_cnt
);
  logic             e_wreg, e_m2reg, m_wreg, m_m2reg, stall;
  logic [REG_W-1:0] e_dest, m_dest;
  always_comb begin
    stall  = d_valid && !hold && e_wreg && e_m2reg && (e_dest != '0) &&
             ((d_use_rs && e_dest == d_rs) || (d_use_rt && e_dest == d_rt));
    wpcir  = !stall && !hold;
    bubble = stall || !d_valid;
  end
  fwd_sel u_fwd_a (
    .use_s(d_use_rs), .s(d_rs),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_dest(e_dest),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_dest(m_dest),
    .sel(fwda)
  );
  fwd_sel u_fwd_b (
    .use_s(d_use_rt), .s(d_rt),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_dest(e_dest),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_dest(m_dest),
    .sel(fwdb)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      e_wreg    <= 1'b0;
      e_m2reg   <= 1'b0;
      e_dest    <= '0;
      m_wreg    <= 1'b0;
      m_m2reg   <= 1'b0;
      m_dest    <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      m_wreg    <= e_wreg;
      m_m2reg   <= e_m2reg;
      m_dest    <= e_dest;
      e_wreg    <= d_wreg && !bubble;
      e_m2reg   <= d_m2reg && !bubble;
      e_dest    <= d_dest;
      stall_cnt <= (stall && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
endmodule
